// File: rtl/pc_debug_sequencer_pkg.sv
// Shared definitions for the PC debug sequencer: command bytes, FSM states and
// the bit positions inside the report flag field.
package pc_debug_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h72;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_CLEAR = 8'h63;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  localparam int FLG_REJ  = 0;
  localparam int FLG_HALT = 1;
  localparam int FLG_TO   = 2;

  // Commands that would advance the pipeline; these are refused once halted.
  function automatic logic is_exec_cmd(input logic [7:0] b);
    return (b == CMD_RUN) || (b == CMD_STEP);
  endfunction

endpackage

// File: rtl/pc_debug_sequencer_if.sv
// Command (UART rx) and report (UART tx) handshakes of the debug sequencer.
// The master modport is the sequencer side, the slave modport the UART side.
interface pc_debug_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int CYC_W  = 16
);
  logic [7:0]        cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [ADDR_W-1:0] rpt_pc;
  logic [CYC_W-1:0]  rpt_cycles;
  logic [2:0]        rpt_flags;

  modport master (
    input  cmd_data, cmd_valid, rpt_ready,
    output cmd_ready, rpt_valid, rpt_pc, rpt_cycles, rpt_flags
  );

  modport slave (
    output cmd_data, cmd_valid, rpt_ready,
    input  cmd_ready, rpt_valid, rpt_pc, rpt_cycles, rpt_flags
  );
endinterface

// File: rtl/pc_debug_sequencer_cycle_counter.sv
// Saturating executed-cycle counter; clear has priority over increment.
module debug_cycle_counter #(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CYC_W-1:0] count
);
  logic [CYC_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pc_debug_sequencer.sv
// Debug-mode controller: decodes run/step/clear bytes, drives the PC/pipeline
// enable and reset, and returns a PC / cycle-count / flags report.
module pc_debug_sequencer
  import pc_debug_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 'hFFFF,
  parameter int RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_debug_sequencer_if.master  bus,
  input  logic                  halt_in,
  input  logic [ADDR_W-1:0]     pc_in,
  output logic                  enableDebug,
  output logic                  resetDebug,
  output logic                  busy
);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e            state_d, state_q;
  logic              halted_d, halted_q;
  logic              rejected_d, rejected_q;
  logic              timeout_d, timeout_q;
  logic              rpt_valid_d, rpt_valid_q;
  logic [ADDR_W-1:0] rpt_pc_d, rpt_pc_q;
  logic [CYC_W-1:0]  rpt_cycles_d, rpt_cycles_q;
  logic [RC_W-1:0]   rst_cnt_d, rst_cnt_q;
  logic              cnt_clr;
  logic [CYC_W-1:0]  cycle_count;
  logic [2:0]        flags;

  debug_cycle_counter #(.CYC_W(CYC_W)) u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (enableDebug),
    .clr   (cnt_clr),
    .count (cycle_count)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    rejected_d   = rejected_q;
    timeout_d    = timeout_q;
    rpt_valid_d  = rpt_valid_q;
    rpt_pc_d     = rpt_pc_q;
    rpt_cycles_d = rpt_cycles_q;
    rst_cnt_d    = rst_cnt_q;
    enableDebug  = 1'b0;
    resetDebug   = 1'b0;
    cnt_clr      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (is_exec_cmd(bus.cmd_data) && halted_q) begin
            rejected_d = 1'b1;
            state_d    = ST_REPORT;
          end else if (bus.cmd_data == CMD_RUN) begin
            state_d = ST_RUN;
          end else if (bus.cmd_data == CMD_STEP) begin
            state_d = ST_STEP;
          end else if (bus.cmd_data == CMD_CLEAR) begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_RUN: begin
        enableDebug = !halt_in;
        if (halt_in) begin
          halted_d = 1'b1;
          state_d  = ST_REPORT;
        end else if (cycle_count >= CYC_W'(MAX_CYCLES - 1)) begin
          // >= also stops a run whose count was pushed past the limit by steps.
          timeout_d = 1'b1;
          state_d   = ST_REPORT;
        end
      end
      ST_STEP: begin
        enableDebug = !halt_in;
        if (halt_in) halted_d = 1'b1;
        state_d = ST_REPORT;
      end
      ST_CLEAR: begin
        resetDebug = 1'b1;
        cnt_clr    = 1'b1;
        halted_d   = 1'b0;
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          rst_cnt_d = '0;
          state_d   = ST_REPORT;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      ST_REPORT: begin
        // First REPORT cycle captures PC/count after the last enabled edge has landed.
        if (!rpt_valid_q) begin
          rpt_pc_d     = pc_in;
          rpt_cycles_d = cycle_count;
          rpt_valid_d  = 1'b1;
        end else if (bus.rpt_ready) begin
          rpt_valid_d = 1'b0;
          rejected_d  = 1'b0;
          timeout_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      halted_q     <= 1'b0;
      rejected_q   <= 1'b0;
      timeout_q    <= 1'b0;
      rpt_valid_q  <= 1'b0;
      rpt_pc_q     <= '0;
      rpt_cycles_q <= '0;
      rst_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      rejected_q   <= rejected_d;
      timeout_q    <= timeout_d;
      rpt_valid_q  <= rpt_valid_d;
      rpt_pc_q     <= rpt_pc_d;
      rpt_cycles_q <= rpt_cycles_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  always_comb begin
    flags         = '0;
    flags[FLG_REJ]  = rejected_q;
    flags[FLG_HALT] = halted_q;
    flags[FLG_TO]   = timeout_q;
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.rpt_valid  = rpt_valid_q;
  assign bus.rpt_pc     = rpt_pc_q;
  assign bus.rpt_cycles = rpt_cycles_q;
  assign bus.rpt_flags  = flags;
  assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pc_debug_sequencer.sv
// Self-checking bench for pc_debug_sequencer: directed scenarios plus a random
// command mix, all checked against a command-level model of the debug rules.
module tb_pc_debug_sequencer;
  import pc_debug_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int CYC_W      = 16;
  localparam int MAX_CYCLES = 20;
  localparam int RST_CYCLES = 2;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              halt_in = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              enableDebug, resetDebug, busy;

  int nchk = 0;
  int nfail = 0;
  int en_total = 0;
  int rd_total = 0;
  int overlap = 0;

  // Command-level model state.
  int m_cycles = 0;
  int m_pc = 0;
  bit m_halted = 1'b0;

  always #5 clk = ~clk;

  pc_debug_sequencer_if #(.ADDR_W(ADDR_W), .CYC_W(CYC_W)) bus ();

  pc_debug_sequencer #(
    .ADDR_W(ADDR_W), .CYC_W(CYC_W), .MAX_CYCLES(MAX_CYCLES), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .halt_in    (halt_in),
    .pc_in      (pc),
    .enableDebug(enableDebug),
    .resetDebug (resetDebug),
    .busy       (busy)
  );

  // Program_Counter stand-in plus pulse bookkeeping.
  always @(posedge clk) begin
    if (resetDebug === 1'b1)       pc <= '0;
    else if (enableDebug === 1'b1) pc <= pc + ADDR_W'(1);
    if (enableDebug === 1'b1) en_total <= en_total + 1;
    if (resetDebug === 1'b1)  rd_total <= rd_total + 1;
    if (enableDebug === 1'b1 && resetDebug === 1'b1) overlap <= overlap + 1;
  end

  task automatic send_byte(input logic [7:0] b, input string name);
    @(negedge clk);
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
    nchk++;
    if (bus.cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL %s cmd_ready got %b want 1 (accept wait expired)", name, bus.cmd_ready);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Issue one command, raise halt_in after n_halt enabled cycles, hold off the
  // report for 'delay' cycles (optionally presenting a CLEAR byte meanwhile).
  task automatic exec_cmd(input logic [7:0] cmd, input int n_halt, input int delay,
                          input bit poke, input string name);
    int en0, rd0, e_en, e_rd, limit;
    logic [ADDR_W-1:0] e_pc;
    logic [CYC_W-1:0]  e_cyc;
    logic [2:0]        e_flags;
    bit got, halt_seen;

    e_en = 0;
    e_rd = 0;
    if (cmd == CMD_CLEAR) begin
      m_cycles = 0; m_pc = 0; m_halted = 1'b0;
      e_flags = 3'b000; e_rd = RST_CYCLES;
    end else if (m_halted) begin
      e_flags = 3'b011;
    end else if (cmd == CMD_STEP) begin
      if (n_halt == 0) begin m_halted = 1'b1; e_flags = 3'b010; end
      else begin e_en = 1; e_flags = 3'b000; end
    end else begin
      limit = MAX_CYCLES - m_cycles;
      if (n_halt < limit) begin e_en = n_halt; m_halted = 1'b1; e_flags = 3'b010; end
      else begin e_en = limit; e_flags = 3'b100; end
    end
    m_cycles += e_en;
    m_pc     += e_en;
    e_pc  = ADDR_W'(m_pc);
    e_cyc = CYC_W'(m_cycles);

    en0 = en_total;
    rd0 = rd_total;
    send_byte(cmd, name);
    got = 1'b0;
    halt_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      halt_in = (en_total - en0 >= n_halt);
      if (halt_in && !halt_seen) begin
        halt_seen = 1'b1;
        #1;
        nchk++;
        if (enableDebug !== 1'b0) begin
          nfail++;
          $display("FAIL %s enable_in_halt_cycle got %b want 0", name, enableDebug);
        end
      end
      if (bus.rpt_valid === 1'b1) begin got = 1'b1; break; end
    end
    nchk++;
    if (!got) begin
      nfail++;
      $display("FAIL %s rpt_valid never asserted (wait expired)", name);
    end
    nchk++;
    if (bus.rpt_pc !== e_pc) begin
      nfail++; $display("FAIL %s rpt_pc got %0d want %0d", name, bus.rpt_pc, e_pc);
    end
    nchk++;
    if (bus.rpt_cycles !== e_cyc) begin
      nfail++; $display("FAIL %s rpt_cycles got %0d want %0d", name, bus.rpt_cycles, e_cyc);
    end
    nchk++;
    if (bus.rpt_flags !== e_flags) begin
      nfail++; $display("FAIL %s rpt_flags got %b want %b", name, bus.rpt_flags, e_flags);
    end

    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (poke && d == 0) begin bus.cmd_data = CMD_CLEAR; bus.cmd_valid = 1'b1; end
      nchk++;
      if (bus.rpt_valid !== 1'b1 || bus.rpt_pc !== e_pc || bus.rpt_cycles !== e_cyc ||
          bus.rpt_flags !== e_flags || bus.cmd_ready !== 1'b0) begin
        nfail++;
        $display("FAIL %s hold cycle %0d got v=%b pc=%0d cyc=%0d fl=%b rdy=%b want v=1 pc=%0d cyc=%0d fl=%b rdy=0",
                 name, d, bus.rpt_valid, bus.rpt_pc, bus.rpt_cycles, bus.rpt_flags,
                 bus.cmd_ready, e_pc, e_cyc, e_flags);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rpt_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rpt_ready = 1'b0;
    halt_in = 1'b0;
    @(negedge clk);
    nchk++;
    if (busy !== 1'b0 || bus.rpt_valid !== 1'b0) begin
      nfail++; $display("FAIL %s after_accept busy=%b rpt_valid=%b want 0 0", name, busy, bus.rpt_valid);
    end
    nchk++;
    if (en_total - en0 !== e_en) begin
      nfail++; $display("FAIL %s enable_cycles got %0d want %0d", name, en_total - en0, e_en);
    end
    nchk++;
    if (rd_total - rd0 !== e_rd) begin
      nfail++; $display("FAIL %s reset_cycles got %0d want %0d", name, rd_total - rd0, e_rd);
    end
  endtask

  task automatic test_junk(input logic [7:0] b, input string name);
    int en0, rd0;
    en0 = en_total;
    rd0 = rd_total;
    send_byte(b, name);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if (busy !== 1'b0 || bus.rpt_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        nfail++;
        $display("FAIL %s idle got busy=%b rpt_valid=%b cmd_ready=%b want 0 0 1",
                 name, busy, bus.rpt_valid, bus.cmd_ready);
      end
    end
    nchk++;
    if (en_total != en0 || rd_total != rd0) begin
      nfail++; $display("FAIL %s pulses got en=%0d rd=%0d want 0 0", name, en_total - en0, rd_total - rd0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nchk++;
    if (bus.cmd_ready !== 1'b1) begin nfail++; $display("FAIL reset cmd_ready got %b want 1", bus.cmd_ready); end
    nchk++;
    if (enableDebug !== 1'b0 || resetDebug !== 1'b0) begin
      nfail++; $display("FAIL reset en/rst got %b %b want 0 0", enableDebug, resetDebug);
    end
    nchk++;
    if (busy !== 1'b0 || bus.rpt_valid !== 1'b0) begin
      nfail++; $display("FAIL reset busy/rpt_valid got %b %b want 0 0", busy, bus.rpt_valid);
    end
    nchk++;
    if (bus.rpt_pc !== '0 || bus.rpt_cycles !== '0 || bus.rpt_flags !== 3'b000) begin
      nfail++; $display("FAIL reset rpt got pc=%0d cyc=%0d fl=%b want 0 0 000",
                        bus.rpt_pc, bus.rpt_cycles, bus.rpt_flags);
    end
    reset = 1'b1;
  endtask

  task automatic test_step();
    exec_cmd(CMD_STEP, 1000, 0, 1'b0, "t1_step");
  endtask

  task automatic test_run_halt();
    exec_cmd(CMD_RUN, 5, 0, 1'b0, "t2_run_halt");
  endtask

  task automatic test_rejected_clear();
    exec_cmd(CMD_STEP, 1000, 2, 1'b0, "t3_rejected_step");
    exec_cmd(CMD_RUN, 1000, 0, 1'b0, "t3_rejected_run");
    exec_cmd(CMD_CLEAR, 1000, 0, 1'b0, "t3_clear");
  endtask

  task automatic test_timeout();
    exec_cmd(CMD_RUN, 1000, 1, 1'b0, "t4_timeout");
    exec_cmd(CMD_CLEAR, 1000, 0, 1'b0, "t4_clear");
    exec_cmd(CMD_RUN, MAX_CYCLES - 1, 0, 1'b0, "t4_halt_wins");
    exec_cmd(CMD_CLEAR, 1000, 0, 1'b0, "t4_clear2");
  endtask

  task automatic test_backpressure();
    exec_cmd(CMD_STEP, 1000, 10, 1'b1, "t5_backpressure");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          if (!m_halted && m_cycles >= MAX_CYCLES) exec_cmd(CMD_CLEAR, 1000, 0, 1'b0, "rnd_preclear");
          exec_cmd(CMD_RUN, $urandom_range(0, 24), $urandom_range(0, 3), 1'b0, "rnd_run");
        end
        1: exec_cmd(CMD_STEP, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, "rnd_step");
        2: exec_cmd(CMD_CLEAR, 1000, $urandom_range(0, 3), 1'b0, "rnd_clear");
        default: begin
          b = 8'($urandom_range(0, 255));
          if (is_exec_cmd(b) || b == CMD_CLEAR) b = b ^ 8'h80;
          test_junk(b, "rnd_junk");
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_run();
    exec_cmd(CMD_CLEAR, 1000, 0, 1'b0, "t6_clear");
    test_junk(8'h41, "t6_junk_41");
    send_byte(CMD_RUN, "t6_run");
    repeat (3) @(negedge clk);
    nchk++;
    if (busy !== 1'b1 || enableDebug !== 1'b1) begin
      nfail++; $display("FAIL t6 running got busy=%b en=%b want 1 1", busy, enableDebug);
    end
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    nchk++;
    if (enableDebug !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rpt_valid !== 1'b0) begin
      nfail++; $display("FAIL t6 after_reset got en=%b busy=%b rdy=%b rv=%b want 0 0 1 0",
                        enableDebug, busy, bus.cmd_ready, bus.rpt_valid);
    end
    nchk++;
    if (bus.rpt_flags !== 3'b000) begin
      nfail++; $display("FAIL t6 flags got %b want 000", bus.rpt_flags);
    end
    m_cycles = 0;
    m_halted = 1'b0;
    m_pc     = int'(pc);
    exec_cmd(CMD_STEP, 1000, 0, 1'b0, "t6_step_after_reset");
  endtask

  initial begin
    bus.cmd_data  = '0;
    bus.cmd_valid = 1'b0;
    bus.rpt_ready = 1'b0;
    test_reset();
    test_step();
    test_run_halt();
    test_rejected_clear();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    nchk++;
    if (overlap !== 0) begin
      nfail++; $display("FAIL exclusive en_and_rst cycles got %0d want 0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
